// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer over one full_adder cell; SERIAL_ADD_OVF_EN adds signed overflow output ovf
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d, sum_q, sum_d;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic fa_sum, fa_cout;
  full_adder u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );
  // next state: capture on start, one bit per RUN cycle, publish the result on the way into DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        a_sh_d  = a_in;
        b_sh_d  = b_in;
        carry_d = cin_in;
        cnt_d   = '0;
      end
      RUN: begin
        carry_d  = fa_cout;
        res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = res_sh_d;
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end
  assign busy     = state_q == RUN;
  assign done     = state_q == DONE;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for the bit-serial adder at WIDTH=8 and WIDTH=2
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start2 = 1'b0, cin2 = 1'b0, busy2, done2, cout2;
  logic [1:0] a2 = '0, b2 = '0, sum2;
  logic [8:0] q8[$];
  logic [2:0] q2[$];
  int total = 0;
  int bad = 0;
`ifdef SERIAL_ADD_OVF_EN
  logic ovf8, ovf2;
`endif
  always #5 clk = ~clk;
  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .cin_in(cin8),
    .busy(busy8), .done(done8), .sum_out(sum8), .cout_out(cout8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf8)
`endif
  );
  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2), .cin_in(cin2),
    .busy(busy2), .done(done2), .sum_out(sum2), .cout_out(cout2)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf2)
`endif
  );

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(posedge clk) #1;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
    @(posedge clk) #1;
    start8 = 1'b0;
    a8 = ~a; b8 = ~b; cin8 = ~c;
  endtask

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic c);
    @(posedge clk) #1;
    a2 = a; b2 = b; cin2 = c; start2 = 1'b1;
    q2.push_back({1'b0, a} + {1'b0, b} + 3'(c));
    @(posedge clk) #1;
    start2 = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({busy8, done8, sum8, cout8, busy2, done2, sum2, cout2} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, need all zero", busy8, done8, sum8, cout8);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] ta[6] = '{8'hFF, 8'h55, 8'h00, 8'h80, 8'h3C, 8'hFF};
    logic [7:0] tb_[6] = '{8'h01, 8'hAA, 8'h00, 8'h80, 8'h4B, 8'hFF};
    logic tc[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      int n = 0, nb = 0;
      logic [8:0] exp;
      issue8(ta[i], tb_[i], tc[i]);
      while (!done8 && n < 40) begin
        @(negedge clk);
        n++;
        if (busy8) nb++;
      end
      exp = q8.pop_front();
      total++;
      if (n !== 9) begin
        bad++;
        $display("FAIL basic_latency[%0d]: got %0d cycles, need 9", i, n);
      end
      total++;
      if (nb !== 8) begin
        bad++;
        $display("FAIL basic_busy[%0d]: got %0d busy cycles, need 8", i, nb);
      end
      total++;
      if ({cout8, sum8} !== exp) begin
        bad++;
        $display("FAIL basic_result[%0d]: got %h, need %h", i, {cout8, sum8}, exp);
      end
      @(negedge clk);
      total++;
      if (done8 !== 1'b0 || {cout8, sum8} !== exp) begin
        bad++;
        $display("FAIL basic_hold[%0d]: got done=%b res=%h, need done=0 res=%h", i, done8, {cout8, sum8}, exp);
      end
    end
  endtask

  task automatic test_ignore_start;
    int n = 0, extra = 0;
    logic [8:0] exp;
    issue8(8'h12, 8'h34, 1'b0);
    repeat (3) @(negedge clk);
    a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    exp = q8.pop_front();
    total++;
    if ({cout8, sum8} !== exp) begin
      bad++;
      $display("FAIL ignore_result: got %h, need %h", {cout8, sum8}, exp);
    end
    repeat (14) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    total++;
    if (extra !== 0) begin
      bad++;
      $display("FAIL ignore_extra_op: got %0d active cycles after done, need 0", extra);
    end
  endtask

  task automatic test_reset_mid_run;
    int n = 0, act = 0;
    logic [8:0] exp;
    issue8(8'hC3, 8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    void'(q8.pop_front());
    total++;
    if ({busy8, done8, sum8, cout8} !== '0) begin
      bad++;
      $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b, need all zero", busy8, done8, sum8, cout8);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) act++;
    end
    total++;
    if (act !== 0) begin
      bad++;
      $display("FAIL midrun_no_done: got %0d active cycles, need 0", act);
    end
    issue8(8'h9E, 8'h71, 1'b0);
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    exp = q8.pop_front();
    total++;
    if (n !== 9 || {cout8, sum8} !== exp) begin
      bad++;
      $display("FAIL midrun_restart: got %0d cycles res=%h, need 9 cycles res=%h", n, {cout8, sum8}, exp);
    end
  endtask

  task automatic test_exhaustive_w2;
    for (int v = 0; v < 32; v++) begin
      int n = 0;
      logic [2:0] exp;
      logic [4:0] vv;
      vv = 5'(v);
      issue2(vv[4:3], vv[2:1], vv[0]);
      while (!done2 && n < 20) begin
        @(negedge clk);
        n++;
      end
      exp = q2.pop_front();
      total++;
      if (n !== 3 || {cout2, sum2} !== exp) begin
        bad++;
        $display("FAIL w2_add[%0d]: got %0d cycles res=%h, need 3 cycles res=%h", v, n, {cout2, sum2}, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int last = -1, cnt = 0;
    @(posedge clk) #1;
    a2 = 2'd3; b2 = 2'd2; cin2 = 1'b1; start2 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done2) begin
        cnt++;
        total++;
        if ({cout2, sum2} !== 3'd6 || (last >= 0 && c - last !== 4)) begin
          bad++;
          $display("FAIL b2b_done[%0d]: got res=%h gap=%0d, need res=6 gap=4", cnt, {cout2, sum2}, c - last);
        end
        last = c;
      end
    end
    start2 = 1'b0;
    total++;
    if (cnt < 7) begin
      bad++;
      $display("FAIL b2b_count: got %0d done pulses, need at least 7", cnt);
    end
    repeat (6) @(negedge clk);
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf;
    logic [7:0] ta[2] = '{8'h7F, 8'hFF};
    logic eo[2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      int n = 0;
      logic [8:0] exp;
      issue8(ta[i], 8'h01, 1'b0);
      while (!done8 && n < 40) begin
        @(negedge clk);
        n++;
      end
      exp = q8.pop_front();
      total++;
      if (ovf8 !== eo[i] || {cout8, sum8} !== exp) begin
        bad++;
        $display("FAIL ovf[%0d]: got ovf=%b res=%h, need ovf=%b res=%h", i, ovf8, {cout8, sum8}, eo[i], exp);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_ignore_start;
    test_reset_mid_run;
    test_exhaustive_w2;
    test_back_to_back;
`ifdef SERIAL_ADD_OVF_EN
    test_ovf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
